// File: rtl/fixed_div_pkg.sv
// fixed_div_pkg: shared widths, FSM encodings and saturation constants for the divider
package fixed_div_pkg;
   localparam int DATA_SIZE = 16;
   localparam int QUAN_SIZE = 8;
   localparam int W = DATA_SIZE + QUAN_SIZE;
   localparam int DIV_CNT_SIZE = $clog2(W + 1);
   localparam logic [1:0] DIV_IDLE = 2'd0;
   localparam logic [1:0] DIV_CALC = 2'd1;
   localparam logic [1:0] DIV_DONE = 2'd2;
   localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
   // unsigned magnitude; the most negative value maps onto itself, read as 2^(DATA_SIZE-1)
   function automatic logic [DATA_SIZE-1:0] abs_mag(input logic [DATA_SIZE-1:0] v);
      return v[DATA_SIZE-1] ? -v : v;
   endfunction
endpackage

// File: rtl/fixed_div_step.sv
// fixed_div_step: one combinational restoring-division step
module fixed_div_step
   import fixed_div_pkg::*;
(
   input  logic [DATA_SIZE-1:0] rem_i,
   input  logic                 bit_i,
   input  logic [DATA_SIZE-1:0] div_i,
   output logic [DATA_SIZE-1:0] rem_o,
   output logic                 q_o
);
   logic [DATA_SIZE:0] sh, diff;
   assign sh    = {rem_i, bit_i};
   assign diff  = sh - {1'b0, div_i};
   assign q_o   = ~diff[DATA_SIZE];
   assign rem_o = q_o ? diff[DATA_SIZE-1:0] : sh[DATA_SIZE-1:0];
endmodule

// File: rtl/fixed_div.sv
// fixed_div: sequential signed fixed-point restoring divider with valid/ready handshakes
module fixed_div
   import fixed_div_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] div_in_1,
   input  logic [DATA_SIZE-1:0] div_in_2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] div_out,
   output logic                 div_ovf,
   output logic                 div_zero
);
   localparam logic [DIV_CNT_SIZE-1:0] CNT_W   = DIV_CNT_SIZE'(W);
   localparam logic [DIV_CNT_SIZE-1:0] CNT_ONE = DIV_CNT_SIZE'(1);
   localparam logic [W-1:0] POS_LIM = W'(SAT_MAX);
   localparam logic [W-1:0] NEG_LIM = W'(SAT_MIN);
   logic [1:0] state_q, state_d;
   logic [DIV_CNT_SIZE-1:0] cnt_q, cnt_d;
   logic [W-1:0] dvd_q, dvd_d, quo_q, quo_d, q_full;
   logic [DATA_SIZE-1:0] div_q, div_d, rem_q, rem_d, res_q, res_d, step_rem, res;
   logic sign_q, sign_d, zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, q_bit, ovf;
   fixed_div_step u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[W-1]),
      .div_i (div_q),
      .rem_o (step_rem),
      .q_o   (q_bit)
   );
   assign q_full    = {quo_q[W-2:0], q_bit};
   assign ovf       = sign_q ? q_full > NEG_LIM : q_full > POS_LIM;
   assign res       = (zero_q | ovf) ? (sign_q ? SAT_MIN : SAT_MAX)
                    : sign_q ? -q_full[DATA_SIZE-1:0] : q_full[DATA_SIZE-1:0];
   assign in_ready  = state_q == DIV_IDLE;
   assign out_valid = state_q == DIV_DONE;
   assign div_out   = res_q;
   assign div_ovf   = ovf_q;
   assign div_zero  = dz_q;
   // next state: accept, iterate, publish; a zero divisor makes a single pass through CALC so it lands one edge after accept
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      div_d   = div_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      if (state_q == DIV_IDLE && in_valid) begin
         state_d = DIV_CALC;
         zero_d  = div_in_2 == '0;
         cnt_d   = (div_in_2 == '0) ? CNT_ONE : CNT_W;
         dvd_d   = {abs_mag(div_in_1), {QUAN_SIZE{1'b0}}};
         div_d   = abs_mag(div_in_2);
         rem_d   = '0;
         quo_d   = '0;
         sign_d  = div_in_1[DATA_SIZE-1] ^ div_in_2[DATA_SIZE-1];
      end
      if (state_q == DIV_CALC) begin
         dvd_d = dvd_q << 1;
         rem_d = step_rem;
         quo_d = q_full;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_ONE) begin
            state_d = DIV_DONE;
            res_d   = res;
            ovf_d   = ovf & ~zero_q;
            dz_d    = zero_q;
         end
      end
      if (state_q == DIV_DONE && out_ready) state_d = DIV_IDLE;
   end
   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end
endmodule
